mips_multicycle_exec: RTL and testbench
=======================================

Name: mips_multicycle_exec

Overview:
Parametrised multi-cycle successor to the single-cycle ADDI datapath. It accepts one 32-bit MIPS instruction at a time over a valid/ready handshake. Each instruction runs through an FSM (DECODE, EXEC, MEM, WB) against an internal register file, ALU and a handshaked data-memory port. It adds R-type/I-type ALU ops, LW/SW with wait states, BEQ resolution, overflow/illegal exceptions and a debug register read port.

Parameters:
XLEN, 32, datapath and register width (16..64)
NREG, 32, number of architectural registers (power of 2, 2..32); r0 hardwired to 0

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
instr_valid  in  1  instruction offered
instr_ready  out  1  block is in IDLE and can accept
instr  in  32  MIPS machine code, sampled on accept
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = store (SW), 0 = load (LW); valid while mem_req
mem_addr  out  XLEN  rs + sext(imm)
mem_wdata  out  XLEN  rt value for SW
mem_rdata  in  XLEN  load data, valid with mem_ack
mem_ack  in  1  completes the request this cycle
done  out  1  one-cycle pulse in WB
result  out  XLEN  ALU result, or load data for LW; held until next done
status  out  8  [7] zero, [6] negative, [5] carry, [4] overflow, [3:0] 0; held
branch_taken  out  1  BEQ and rs==rt; valid with done
branch_offset  out  XLEN  sext(imm)<<2 for BEQ, else 0; valid with done
exception  out  1  illegal op/register or signed overflow; valid with done
dbg_raddr  in  5  debug register index
dbg_rdata  out  XLEN  combinational register-file read (0 if index>=NREG)

Behaviour:
- Reset (rst_n=0 at edge): FSM to IDLE; all registers cleared to 0; instr_ready=1 after reset; mem_req, done, branch_taken and exception =0; result, status, branch_offset =0. Reset mid-operation aborts it with no register write, and mem_req drops on that same edge.
- Accept: instr_valid & instr_ready in IDLE latches instr into IR. Next state DECODE. instr_ready=1 only in IDLE.
- DECODE (1 cycle): A<=reg[rs], B<=reg[rt]. Imm is sign-extended for ADDI/SLTI/LW/SW/BEQ and zero-extended for ANDI/ORI.
- Illegal check in DECODE: any rs/rt/rd index >= NREG, or an unsupported opcode/funct, sets the exception flag and jumps to WB with no write.
- EXEC (1 cycle): ALUOut computed at XLEN bits.
  - R-type (op 0) funct: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A.
  - I-type: ADDI 0x08, SLTI 0x0A, ANDI 0x0C, ORI 0x0D, LW 0x23, SW 0x2B, BEQ 0x04.
  - Carry = unsigned carry-out (SUB: no-borrow). Overflow = signed overflow for ADD/SUB/ADDI, else 0.
  - SLT/SLTI are signed and give 1 or 0.
- ADD/SUB/ADDI with overflow: exception=1, no register write. Status is still updated.
- EXEC to MEM for LW/SW, else to WB.
- MEM: mem_req=1 and mem_we=(SW). Addr/wdata are stable while waiting, with no timeout.
  - mem_ack in the same cycle as the first mem_req is legal.
  - On ack, LW captures mem_rdata. mem_req drops on the next edge, then WB.
- WB (1 cycle): done=1. Writes the register file, never to index 0:
  - R-type writes rd; ADDI/SLTI/ANDI/ORI/LW write rt.
  - result/status/branch outputs update.
  - Status is taken from ALUOut, or from load data for LW (carry=overflow=0 for LW).
  - Then IDLE.
- Latency from accept to done: 3 cycles for ALU/BEQ/illegal (done at cycle N+3), 4+wait cycles for LW/SW.
- dbg_rdata reflects the WB write from the edge after the write.
- Writes to r0 are discarded; r0 always reads 0.

Test Plan:
- ADDI r1,r0,5 (0x20010005), then ADD r2,r1,r1 -> done 3 cycles after each accept; result=10; dbg r2=10; status=0x00.
- SUB r3,r1,r1 -> result=0, status[7]=1; BEQ r1,r1,-1 (0x1021FFFF) -> branch_taken=1, branch_offset=0xFFFFFFFC, no register write.
- r1=0x7FFFFFFF, ADD r2,r1,r1 -> exception=1, status[4]=1, r2 unchanged. ANDI r4,r1,0xFFFF gives 0x0000FFFF (zero-extended).
- SW r1,4(r0) with mem_ack delayed 3 cycles -> mem_req held 4 cycles, addr=4, wdata=r1. LW r5,4(r0) with ack returning 0xDEADBEEF -> r5=0xDEADBEEF, status[6]=1.
- NREG=8: ADD r9,r1,r1 -> exception=1, no write. Opcode 0x3F -> exception=1, done after 3 cycles.
- rst_n=0 during MEM wait -> mem_req=0 after that edge, all registers 0, instr_ready=1 next cycle.

Source files
------------

// File: rtl/mips_multicycle_exec.sv
// Multi-cycle MIPS execute block: one instruction at a time through
// DECODE / EXEC / MEM / WB against an internal register file and a
// handshaked data-memory port.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for an instruction, instr_ready=1
// DECODE | read rs/rt into A/B, extend immediate, detect illegal encodings
// EXEC   | ALU operation, flags and branch resolution
// MEM    | LW/SW request held until mem_ack
// WB     | done pulse, register-file write
module mips_multicycle_exec #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [31:0]     instr,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic [XLEN-1:0] mem_rdata,
   input  logic            mem_ack,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [7:0]      status,
   output logic            branch_taken,
   output logic [XLEN-1:0] branch_offset,
   output logic            exception,
   input  logic [4:0]      dbg_raddr,
   output logic [XLEN-1:0] dbg_rdata
);

   localparam int IW = $clog2(NREG);

   typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM, S_WB} state_t;
   typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT} aluop_t;

   state_t state_q, state_d;

   logic [XLEN-1:0] regs_q [NREG];
   logic [31:0]     ir_q;
   logic [XLEN-1:0] a_q, b_q, imm_q, alu_q;
   logic            carry_q, ovf_q, illegal_q;
   logic [XLEN-1:0] result_q, br_off_q;
   logic [7:0]      status_q;
   logic            br_taken_q, exc_q;

   logic [5:0]  op_f, funct_f;
   logic [4:0]  rs_f, rt_f, rd_f, wr_idx;
   logic [15:0] imm_f;
   assign op_f    = ir_q[31:26];
   assign rs_f    = ir_q[25:21];
   assign rt_f    = ir_q[20:16];
   assign rd_f    = ir_q[15:11];
   assign imm_f   = ir_q[15:0];
   assign funct_f = ir_q[5:0];

   logic unused_shamt;
   assign unused_shamt = ^ir_q[10:6];

   aluop_t alu_op;
   logic   legal, is_r, is_lw, is_sw, is_beq, zext, ovf_en, wr_rt, wr_rd, idx_bad;

   // Instruction decode from the latched IR
   always_comb begin
      alu_op = OP_ADD;
      legal  = 1'b1;
      is_r   = 1'b0;
      is_lw  = 1'b0;
      is_sw  = 1'b0;
      is_beq = 1'b0;
      zext   = 1'b0;
      ovf_en = 1'b0;
      wr_rt  = 1'b0;
      wr_rd  = 1'b0;
      case (op_f)
         6'h00: begin
            is_r  = 1'b1;
            wr_rd = 1'b1;
            case (funct_f)
               6'h20: begin alu_op = OP_ADD; ovf_en = 1'b1; end
               6'h22: begin alu_op = OP_SUB; ovf_en = 1'b1; end
               6'h24: alu_op = OP_AND;
               6'h25: alu_op = OP_OR;
               6'h2A: alu_op = OP_SLT;
               default: legal = 1'b0;
            endcase
         end
         6'h08: begin alu_op = OP_ADD; ovf_en = 1'b1; wr_rt = 1'b1; end
         6'h0A: begin alu_op = OP_SLT; wr_rt = 1'b1; end
         6'h0C: begin alu_op = OP_AND; zext = 1'b1; wr_rt = 1'b1; end
         6'h0D: begin alu_op = OP_OR;  zext = 1'b1; wr_rt = 1'b1; end
         6'h23: begin alu_op = OP_ADD; is_lw = 1'b1; wr_rt = 1'b1; end
         6'h2B: begin alu_op = OP_ADD; is_sw = 1'b1; end
         6'h04: begin alu_op = OP_SUB; is_beq = 1'b1; end
         default: legal = 1'b0;
      endcase
      idx_bad = ({27'b0, rs_f} >= NREG) || ({27'b0, rt_f} >= NREG) ||
                (is_r && ({27'b0, rd_f} >= NREG));
   end

   assign wr_idx = wr_rd ? rd_f : rt_f;

   logic [XLEN-1:0] op2, alu_y;
   logic [XLEN:0]   sum_add, sum_sub;
   logic            alu_c, alu_v;

   // ALU: carry is unsigned carry-out (no-borrow for subtraction)
   always_comb begin
      op2     = (is_r || is_beq) ? b_q : imm_q;
      sum_add = {1'b0, a_q} + {1'b0, op2};
      sum_sub = {1'b0, a_q} + {1'b0, ~op2} + {{XLEN{1'b0}}, 1'b1};
      alu_y   = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (alu_op)
         OP_ADD: begin
            alu_y = sum_add[XLEN-1:0];
            alu_c = sum_add[XLEN];
            alu_v = ovf_en && (a_q[XLEN-1] == op2[XLEN-1]) && (alu_y[XLEN-1] != a_q[XLEN-1]);
         end
         OP_SUB: begin
            alu_y = sum_sub[XLEN-1:0];
            alu_c = sum_sub[XLEN];
            alu_v = ovf_en && (a_q[XLEN-1] != op2[XLEN-1]) && (alu_y[XLEN-1] != a_q[XLEN-1]);
         end
         OP_AND: alu_y = a_q & op2;
         OP_OR:  alu_y = a_q | op2;
         OP_SLT: alu_y = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(op2))};
         default: alu_y = '0;
      endcase
   end

   function automatic logic [7:0] flags(input logic [XLEN-1:0] y, input logic c, input logic v);
      return {(y == '0), y[XLEN-1], c, v, 4'b0000};
   endfunction

   // Next-state and handshake outputs; illegal ops still pass EXEC so every
   // non-memory instruction has the same accept-to-done latency
   always_comb begin
      state_d     = state_q;
      instr_ready = 1'b0;
      mem_req     = 1'b0;
      done        = 1'b0;
      case (state_q)
         S_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) state_d = S_DECODE;
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (!illegal_q && (is_lw || is_sw)) state_d = S_MEM;
            else                                state_d = S_WB;
         end
         S_MEM: begin
            mem_req = 1'b1;
            if (mem_ack) state_d = S_WB;
         end
         S_WB: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Datapath registers and the held result/status/branch outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ir_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         imm_q      <= '0;
         alu_q      <= '0;
         carry_q    <= 1'b0;
         ovf_q      <= 1'b0;
         illegal_q  <= 1'b0;
         result_q   <= '0;
         status_q   <= '0;
         br_taken_q <= 1'b0;
         br_off_q   <= '0;
         exc_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: if (instr_valid) ir_q <= instr;
            S_DECODE: begin
               a_q       <= regs_q[rs_f[IW-1:0]];
               b_q       <= regs_q[rt_f[IW-1:0]];
               imm_q     <= zext ? XLEN'(imm_f) : XLEN'($signed(imm_f));
               illegal_q <= !legal || idx_bad;
            end
            S_EXEC: begin
               if (illegal_q) begin
                  exc_q      <= 1'b1;
                  br_taken_q <= 1'b0;
                  br_off_q   <= '0;
               end else begin
                  alu_q   <= alu_y;
                  carry_q <= alu_c;
                  ovf_q   <= alu_v;
                  if (!(is_lw || is_sw)) begin
                     result_q   <= alu_y;
                     status_q   <= flags(alu_y, alu_c, alu_v);
                     exc_q      <= alu_v;
                     br_taken_q <= is_beq && (alu_y == '0);
                     br_off_q   <= is_beq ? (imm_q << 2) : '0;
                  end
               end
            end
            S_MEM: begin
               if (mem_ack) begin
                  result_q   <= is_lw ? mem_rdata : alu_q;
                  status_q   <= is_lw ? flags(mem_rdata, 1'b0, 1'b0) : flags(alu_q, carry_q, ovf_q);
                  exc_q      <= 1'b0;
                  br_taken_q <= 1'b0;
                  br_off_q   <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Register file; r0 is never written so it always reads zero
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (state_q == S_WB && !exc_q && (wr_rd || wr_rt) && wr_idx != 5'd0) begin
         regs_q[wr_idx[IW-1:0]] <= result_q;
      end
   end

   assign mem_we        = is_sw;
   assign mem_addr      = alu_q;
   assign mem_wdata     = b_q;
   assign result        = result_q;
   assign status        = status_q;
   assign branch_taken  = br_taken_q;
   assign branch_offset = br_off_q;
   assign exception     = exc_q;
   assign dbg_rdata     = ({27'b0, dbg_raddr} < NREG) ? regs_q[dbg_raddr[IW-1:0]] : '0;

endmodule

// File: tb/tb_mips_multicycle_exec.sv
// Directed bench for mips_multicycle_exec: a 32-register instance runs the
// main program with a scripted memory responder, an 8-register instance
// covers out-of-range register indices.
module tb_mips_multicycle_exec;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid, instr_ready;
   logic [31:0] instr;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        done, branch_taken, exception;
   logic [31:0] result, branch_offset, dbg_rdata;
   logic [7:0]  status;
   logic [4:0]  dbg_raddr;

   logic        v8, rdy8, req8, we8, done8, bt8, exc8;
   logic [31:0] i8, addr8, wd8, res8, off8, dbg8;
   logic [7:0]  st8;
   logic [4:0]  dbg_raddr8;

   int n_chk = 0;
   int n_pass = 0;

   int          t_lat, t_req;
   logic [31:0] t_res, t_off, t_addr, t_wdata;
   logic [7:0]  t_stat;
   logic        t_br, t_exc, t_we, t_stable;

   always #5 clk = ~clk;

   mips_multicycle_exec #(.XLEN(32), .NREG(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .done(done), .result(result), .status(status),
      .branch_taken(branch_taken), .branch_offset(branch_offset), .exception(exception),
      .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
   );

   mips_multicycle_exec #(.XLEN(32), .NREG(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(v8), .instr_ready(rdy8), .instr(i8),
      .mem_req(req8), .mem_we(we8), .mem_addr(addr8), .mem_wdata(wd8),
      .mem_rdata(32'h0), .mem_ack(1'b0),
      .done(done8), .result(res8), .status(st8),
      .branch_taken(bt8), .branch_offset(off8), .exception(exc8),
      .dbg_raddr(dbg_raddr8), .dbg_rdata(dbg8)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic dbg_chk(input string tag, input logic [4:0] idx, input logic [31:0] exp);
      dbg_raddr = idx;
      #1;
      chk(tag, dbg_rdata, exp);
   endtask

   // Issue one instruction, answer memory after 'dly' unacked request cycles,
   // capture outputs on the done cycle
   task automatic run(input logic [31:0] ins, input int dly, input logic [31:0] rdata);
      logic got;
      @(negedge clk);
      instr = ins;
      instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      t_lat = 0; t_req = 0; got = 1'b0; t_stable = 1'b1;
      while (!got && t_lat < 40) begin
         @(negedge clk);
         t_lat++;
         mem_ack = 1'b0;
         if (mem_req) begin
            t_req++;
            if (t_req > 1 && (mem_addr !== t_addr || mem_wdata !== t_wdata || mem_we !== t_we))
               t_stable = 1'b0;
            t_addr = mem_addr; t_wdata = mem_wdata; t_we = mem_we;
            if (t_req > dly) begin
               mem_ack = 1'b1;
               mem_rdata = rdata;
            end
         end
         if (done) begin
            got = 1'b1;
            t_res = result; t_stat = status; t_br = branch_taken;
            t_off = branch_offset; t_exc = exception;
         end
      end
      if (!got) chk("done_timeout", 0, 1);
      @(negedge clk);
   endtask

   task automatic run8(input logic [31:0] ins);
      logic got;
      @(negedge clk);
      i8 = ins;
      v8 = 1'b1;
      @(posedge clk);
      #1 v8 = 1'b0;
      t_lat = 0; got = 1'b0;
      while (!got && t_lat < 20) begin
         @(negedge clk);
         t_lat++;
         if (done8) begin
            got = 1'b1;
            t_exc = exc8;
         end
      end
      if (!got) chk("done8_timeout", 0, 1);
      @(negedge clk);
   endtask

   initial begin
      logic hit;
      rst_n = 1'b0; instr_valid = 1'b0; instr = '0; mem_ack = 1'b0; mem_rdata = '0;
      dbg_raddr = '0; v8 = 1'b0; i8 = '0; dbg_raddr8 = '0;
      t_addr = '0; t_wdata = '0; t_we = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready", instr_ready, 1);
      chk("rst_req", mem_req, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_status", status, 0);
      chk("rst_exc", exception, 0);
      chk("rst_br", {branch_taken, branch_offset}, 0);
      rst_n = 1'b1;

      run(32'h20010005, 0, 0);                       // ADDI r1,r0,5
      chk("addi_lat", t_lat, 3);
      chk("addi_res", t_res, 5);
      dbg_chk("addi_r1", 1, 5);

      run(32'h00211020, 0, 0);                       // ADD r2,r1,r1
      chk("add_lat", t_lat, 3);
      chk("add_res", t_res, 10);
      chk("add_stat", t_stat, 8'h00);
      dbg_chk("add_r2", 2, 10);

      run(32'h00211822, 0, 0);                       // SUB r3,r1,r1
      chk("sub_res", t_res, 0);
      chk("sub_stat", t_stat, 8'hA0);
      dbg_chk("sub_r3", 3, 0);

      run(32'h1021FFFF, 0, 0);                       // BEQ r1,r1,-1
      chk("beq_lat", t_lat, 3);
      chk("beq_taken", t_br, 1);
      chk("beq_off", t_off, 32'hFFFFFFFC);
      chk("beq_exc", t_exc, 0);
      dbg_chk("beq_r1", 1, 5);

      run(32'h8C010000, 0, 32'h7FFFFFFF);            // LW r1,0(r0), immediate ack
      chk("lw0_lat", t_lat, 4);
      chk("lw0_req", t_req, 1);
      chk("lw0_we", t_we, 0);
      chk("lw0_res", t_res, 32'h7FFFFFFF);
      chk("lw0_br", t_br, 0);
      dbg_chk("lw0_r1", 1, 32'h7FFFFFFF);

      run(32'h00211020, 0, 0);                       // ADD r2,r1,r1 overflows
      chk("ovf_exc", t_exc, 1);
      chk("ovf_stat", t_stat, 8'h50);
      chk("ovf_res", t_res, 32'hFFFFFFFE);
      dbg_chk("ovf_r2", 2, 10);

      run(32'h3024FFFF, 0, 0);                       // ANDI r4,r1,0xFFFF
      chk("andi_res", t_res, 32'h0000FFFF);
      chk("andi_exc", t_exc, 0);
      dbg_chk("andi_r4", 4, 32'h0000FFFF);

      run(32'hAC010004, 3, 0);                       // SW r1,4(r0), 3 wait cycles
      chk("sw_lat", t_lat, 7);
      chk("sw_req", t_req, 4);
      chk("sw_we", t_we, 1);
      chk("sw_addr", t_addr, 4);
      chk("sw_wdata", t_wdata, 32'h7FFFFFFF);
      chk("sw_stable", t_stable, 1);

      run(32'h8C050004, 1, 32'hDEADBEEF);            // LW r5,4(r0)
      chk("lw_lat", t_lat, 5);
      chk("lw_res", t_res, 32'hDEADBEEF);
      chk("lw_stat", t_stat, 8'h40);
      dbg_chk("lw_r5", 5, 32'hDEADBEEF);

      run(32'h00A1302A, 0, 0);                       // SLT r6,r5,r1 (signed)
      chk("slt_res", t_res, 1);
      dbg_chk("slt_r6", 6, 1);

      run(32'h34078000, 0, 0);                       // ORI r7,r0,0x8000
      chk("ori_res", t_res, 32'h00008000);
      chk("ori_stat", t_stat, 8'h00);
      dbg_chk("ori_r7", 7, 32'h00008000);

      run(32'h20000007, 0, 0);                       // ADDI r0,r0,7 discarded
      chk("r0_res", t_res, 7);
      dbg_chk("r0_zero", 0, 0);

      run(32'hFC000000, 0, 0);                       // unsupported opcode 0x3F
      chk("ill_lat", t_lat, 3);
      chk("ill_exc", t_exc, 1);
      chk("ill_br", t_br, 0);

      run8(32'h20010005);                            // NREG=8: ADDI r1,r0,5
      chk("n8_addi_exc", t_exc, 0);
      dbg_raddr8 = 5'd1; #1;
      chk("n8_r1", dbg8, 5);
      run8(32'h00214820);                            // ADD r9,r1,r1 out of range
      chk("n8_lat", t_lat, 3);
      chk("n8_exc", t_exc, 1);
      dbg_raddr8 = 5'd1; #1;
      chk("n8_r1_kept", dbg8, 5);
      dbg_raddr8 = 5'd9; #1;
      chk("n8_dbg_oob", dbg8, 0);

      // reset while LW waits for memory
      @(negedge clk);
      instr = 32'h8C050004;
      instr_valid = 1'b1;
      @(posedge clk);
      #1 instr_valid = 1'b0;
      hit = 1'b0;
      for (int i = 0; i < 10 && !hit; i++) begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (mem_req) hit = 1'b1;
      end
      chk("rst_mem_reached", hit, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_mid_req", mem_req, 0);
      chk("rst_mid_ready", instr_ready, 1);
      chk("rst_mid_result", result, 0);
      dbg_chk("rst_mid_r1", 1, 0);
      dbg_chk("rst_mid_r5", 5, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_mid_ready2", instr_ready, 1);
      chk("rst_mid_done", done, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
